// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like arbiter: fixed data>inst priority with grant locking on the
// address phase, and in-order response routing through a 1-bit owner FIFO.
module sram_like_arbiter #(
   parameter int OUTSTANDING = 2
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         inst_req,
   input  logic                         inst_wr,
   input  logic [1:0]                   inst_size,
   input  logic [3:0]                   inst_wstrb,
   input  logic [31:0]                  inst_addr,
   input  logic [31:0]                  inst_wdata,
   output logic                         inst_addr_ok,
   output logic                         inst_data_ok,
   output logic [31:0]                  inst_rdata,
   input  logic                         data_req,
   input  logic                         data_wr,
   input  logic [1:0]                   data_size,
   input  logic [3:0]                   data_wstrb,
   input  logic [31:0]                  data_addr,
   input  logic [31:0]                  data_wdata,
   output logic                         data_addr_ok,
   output logic                         data_data_ok,
   output logic [31:0]                  data_rdata,
   output logic                         mem_req,
   output logic                         mem_wr,
   output logic [1:0]                   mem_size,
   output logic [3:0]                   mem_wstrb,
   output logic [31:0]                  mem_addr,
   output logic [31:0]                  mem_wdata,
   input  logic                         mem_addr_ok,
   input  logic                         mem_data_ok,
   input  logic [31:0]                  mem_rdata,
   output logic [$clog2(OUTSTANDING):0] outstanding_cnt,
   output logic                         err_orphan_ok
);

   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING) + 1;

   logic          lock_valid;
   logic          lock_owner;
   logic          fifo_q [OUTSTANDING];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;

   logic grant;
   logic gnt_req;
   logic fifo_full;
   logic fifo_empty;
   logic accept;
   logic pop;
   logic head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(OUTSTANDING - 1)) return '0;
      else return p + PW'(1);
   endfunction

   // Grant forced to inst while in reset so the payload idles on the inst master.
   assign grant      = !resetn ? 1'b0 : (lock_valid ? lock_owner : data_req);
   assign gnt_req    = grant ? data_req : inst_req;
   assign fifo_full  = (cnt == CW'(OUTSTANDING));
   assign fifo_empty = (cnt == '0);
   assign mem_req    = resetn & !fifo_full & gnt_req;
   assign accept     = mem_req & mem_addr_ok;
   assign pop        = mem_data_ok & !fifo_empty;
   assign head       = fifo_q[rd_ptr];

   assign mem_wr    = grant ? data_wr    : inst_wr;
   assign mem_size  = grant ? data_size  : inst_size;
   assign mem_wstrb = grant ? data_wstrb : inst_wstrb;
   assign mem_addr  = grant ? data_addr  : inst_addr;
   assign mem_wdata = grant ? data_wdata : inst_wdata;

   assign inst_addr_ok = accept & !grant;
   assign data_addr_ok = accept &  grant;
   assign inst_data_ok = pop & !head;
   assign data_data_ok = pop &  head;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   assign outstanding_cnt = cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_valid    <= 1'b0;
         lock_owner    <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cnt           <= '0;
         err_orphan_ok <= 1'b0;
      end else begin
         // Hold the grant across a stalled address phase, release on accept.
         if (accept) begin
            lock_valid <= 1'b0;
         end else if (mem_req) begin
            lock_valid <= 1'b1;
            lock_owner <= grant;
         end
         if (accept) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)    rd_ptr <= ptr_inc(rd_ptr);
         if (accept && !pop)      cnt <= cnt + CW'(1);
         else if (!accept && pop) cnt <= cnt - CW'(1);
         if (mem_data_ok && fifo_empty) err_orphan_ok <= 1'b1;
      end
   end

   // Owner storage is pure data; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (accept) fifo_q[wr_ptr] <= grant;
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: bench acts as both masters and the slave.
module tb_sram_like_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size, mem_size;
   logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  outstanding_cnt;
   logic        err_orphan_ok;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_like_arbiter #(.OUTSTANDING(2)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .outstanding_cnt(outstanding_cnt), .err_orphan_ok(err_orphan_ok)
   );

   task automatic idle();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
      inst_addr = 32'h1C00_0000; inst_wdata = 32'h1111_1111;
      data_req = 0; data_wr = 1; data_size = 2'd1; data_wstrb = 4'hC;
      data_addr = 32'h8000_0040; data_wdata = 32'hDEAD_BEEF;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
   endtask

   // Advance to 1 time unit after the next rising edge; inputs change there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      resetn = 0;
      data_req = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hA5A5_5A5A;
      #2;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_data_addr_ok got %b exp 0", data_addr_ok); end
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL reset_data_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
      checks++; if (mem_addr !== 32'h1C00_0000) begin errors++; $display("FAIL reset_payload got %h exp 1c000000", mem_addr); end
      checks++; if (outstanding_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", outstanding_cnt); end
      checks++; if (err_orphan_ok !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_orphan_ok); end
      checks++; if (data_rdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL reset_rdata got %h exp a5a55a5a", data_rdata); end
      tick();
      idle();
      resetn = 1;
      tick();
   endtask

   task automatic test_single_inst();
      inst_req = 1; mem_addr_ok = 1;
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_mem_req got %b exp 1", mem_req); end
      checks++; if (mem_addr !== 32'h1C00_0000) begin errors++; $display("FAIL single_addr got %h exp 1c000000", mem_addr); end
      checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL single_addr_ok got %b exp 10", {inst_addr_ok, data_addr_ok}); end
      tick();
      inst_req = 0; mem_addr_ok = 0;
      #1;
      checks++; if (outstanding_cnt !== 2'd1) begin errors++; $display("FAIL single_cnt1 got %0d exp 1", outstanding_cnt); end
      tick();
      mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL single_data_ok got %b exp 10", {inst_data_ok, data_data_ok}); end
      checks++; if (inst_rdata !== 32'h0280_0C0C) begin errors++; $display("FAIL single_rdata got %h exp 02800c0c", inst_rdata); end
      tick();
      idle();
      #1;
      checks++; if (outstanding_cnt !== 2'd0) begin errors++; $display("FAIL single_cnt0 got %0d exp 0", outstanding_cnt); end
   endtask

   task automatic test_priority();
      inst_req = 1; data_req = 1; mem_addr_ok = 1;
      #1;
      checks++; if (mem_addr !== 32'h8000_0040) begin errors++; $display("FAIL prio_addr got %h exp 80000040", mem_addr); end
      checks++; if ({mem_wr, mem_size, mem_wstrb, mem_wdata} !== {1'b1, 2'd1, 4'hC, 32'hDEAD_BEEF}) begin errors++; $display("FAIL prio_payload got %b %0d %h %h exp 1 1 c deadbeef", mem_wr, mem_size, mem_wstrb, mem_wdata); end
      checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("FAIL prio_addr_ok got %b exp 01", {inst_addr_ok, data_addr_ok}); end
      tick();
      data_req = 0;
      #1;
      checks++; if (mem_addr !== 32'h1C00_0000) begin errors++; $display("FAIL prio_inst_addr got %h exp 1c000000", mem_addr); end
      checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL prio_inst_ok got %b exp 10", {inst_addr_ok, data_addr_ok}); end
      tick();
      idle();
      mem_data_ok = 1;
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL prio_resp1 got %b exp 01", {inst_data_ok, data_data_ok}); end
      tick();
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL prio_resp2 got %b exp 10", {inst_data_ok, data_data_ok}); end
      tick();
      idle();
   endtask

   task automatic test_lock();
      inst_req = 1;
      tick();
      data_req = 1;
      for (int c = 1; c <= 2; c++) begin
         #1;
         checks++; if (mem_addr !== 32'h1C00_0000) begin errors++; $display("FAIL lock_addr_c%0d got %h exp 1c000000", c, mem_addr); end
         checks++; if ({mem_req, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL lock_req_c%0d got %b exp 10", c, {mem_req, data_addr_ok}); end
         tick();
      end
      mem_addr_ok = 1;
      #1;
      checks++; if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, 32'h1C00_0000}) begin errors++; $display("FAIL lock_accept_c3 got %b %b %h exp 1 0 1c000000", inst_addr_ok, data_addr_ok, mem_addr); end
      tick();
      inst_req = 0;
      #1;
      checks++; if ({data_addr_ok, mem_addr} !== {1'b1, 32'h8000_0040}) begin errors++; $display("FAIL lock_data_c4 got %b %h exp 1 80000040", data_addr_ok, mem_addr); end
      tick();
      idle();
      mem_data_ok = 1;
      tick();
      tick();
      idle();
      // Locked master withdraws before accept: lock holds against the other master.
      inst_req = 1;
      tick();
      inst_req = 0; data_req = 1; mem_addr_ok = 1;
      #1;
      checks++; if ({mem_req, data_addr_ok, mem_addr} !== {2'b00, 32'h1C00_0000}) begin errors++; $display("FAIL lock_drop got %b %b %h exp 0 0 1c000000", mem_req, data_addr_ok, mem_addr); end
      tick();
      #1;
      checks++; if (outstanding_cnt !== 2'd0) begin errors++; $display("FAIL lock_drop_cnt got %0d exp 0", outstanding_cnt); end
      inst_req = 1; data_req = 0;
      #1;
      checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL lock_resume got %b exp 1", inst_addr_ok); end
      tick();
      idle();
      mem_data_ok = 1;
      tick();
      idle();
   endtask

   task automatic test_full();
      inst_req = 1; mem_addr_ok = 1;
      tick();
      inst_req = 0; data_req = 1;
      tick();
      data_req = 0; inst_req = 1;
      #1;
      checks++; if ({mem_req, inst_addr_ok} !== 2'b00) begin errors++; $display("FAIL full_block got %b exp 00", {mem_req, inst_addr_ok}); end
      checks++; if (outstanding_cnt !== 2'd2) begin errors++; $display("FAIL full_cnt got %0d exp 2", outstanding_cnt); end
      tick();
      mem_data_ok = 1;
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL full_resp1 got %b exp 10", {inst_data_ok, data_data_ok}); end
      checks++; if ({mem_req, inst_addr_ok} !== 2'b00) begin errors++; $display("FAIL full_same_cycle got %b exp 00", {mem_req, inst_addr_ok}); end
      tick();
      mem_data_ok = 0;
      #1;
      checks++; if ({mem_req, inst_addr_ok} !== 2'b11) begin errors++; $display("FAIL full_unblock got %b exp 11", {mem_req, inst_addr_ok}); end
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL full_resp2 got %b exp 01", {inst_data_ok, data_data_ok}); end
      tick();
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL full_resp3 got %b exp 10", {inst_data_ok, data_data_ok}); end
      tick();
      idle();
      #1;
      checks++; if (outstanding_cnt !== 2'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", outstanding_cnt); end
   endtask

   task automatic test_back_to_back();
      data_req = 1; mem_addr_ok = 1;
      tick();
      data_req = 0; inst_req = 1; mem_data_ok = 1;
      #1;
      checks++; if ({inst_addr_ok, data_data_ok} !== 2'b11) begin errors++; $display("FAIL b2b_pushpop got %b exp 11", {inst_addr_ok, data_data_ok}); end
      tick();
      idle();
      #1;
      checks++; if (outstanding_cnt !== 2'd1) begin errors++; $display("FAIL b2b_cnt got %0d exp 1", outstanding_cnt); end
      mem_data_ok = 1;
      #1;
      checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL b2b_resp got %b exp 1", inst_data_ok); end
      tick();
      idle();
   endtask

   task automatic test_orphan();
      mem_data_ok = 1;
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL orphan_no_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
      tick();
      idle();
      #1;
      checks++; if ({err_orphan_ok, outstanding_cnt} !== {1'b1, 2'd0}) begin errors++; $display("FAIL orphan_err got %b %0d exp 1 0", err_orphan_ok, outstanding_cnt); end
      inst_req = 1; mem_addr_ok = 1;
      tick();
      idle();
      #1;
      checks++; if (outstanding_cnt !== 2'd1) begin errors++; $display("FAIL orphan_pending got %0d exp 1", outstanding_cnt); end
      resetn = 0;
      #1;
      checks++; if ({err_orphan_ok, outstanding_cnt} !== {1'b0, 2'd0}) begin errors++; $display("FAIL async_reset got %b %0d exp 0 0", err_orphan_ok, outstanding_cnt); end
      tick();
      resetn = 1;
      tick();
   endtask

   initial begin
      idle();
      resetn = 1;
      #1;
      test_reset();
      test_single_inst();
      test_priority();
      test_lock();
      test_full();
      test_back_to_back();
      test_orphan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-to-one arbiter merging the core's instruction and data SRAM-like request channels onto a single shared SRAM-like memory port. It sits between the gated-clock core wrapper and the unified memory/bridge side. Request/address phase uses fixed priority with grant locking. Response phase is routed in order through an owner FIFO, so several transactions may be outstanding.

## Interface
- OUTSTANDING, 2: max accepted-but-unanswered transactions (power of 2, 1..8); owner FIFO depth.
- clk  in  1  system clock (ungated).
- resetn  in  1  asynchronous active-low reset.
- inst_req / data_req  in  1  master request valid.
- inst_wr / data_wr  in  1  write flag.
- inst_size / data_size  in  2  access size.
- inst_wstrb / data_wstrb  in  4  byte strobes.
- inst_addr / data_addr  in  32  address.
- inst_wdata / data_wdata  in  32  write data.
- inst_addr_ok / data_addr_ok  out  1  address accepted for that master.
- inst_data_ok / data_data_ok  out  1  response for that master.
- inst_rdata / data_rdata  out  32  read data; both driven by mem_rdata.
- mem_req  out  1  shared-port request.
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed from the granted master.
- mem_addr_ok  in  1  slave address accept.
- mem_data_ok  in  1  slave response (in order).
- mem_rdata  in  32  slave read data.
- outstanding_cnt  out  log2(OUTSTANDING)+1  current FIFO occupancy.
- err_orphan_ok  out  1  sticky; set on mem_data_ok while FIFO empty.

## Operation
- State: lock_valid, lock_owner (0 = inst, 1 = data), owner FIFO (OUTSTANDING entries × 1 bit, rd/wr pointers, count), err_orphan_ok.
- Grant: grant = lock_valid ? lock_owner : (data_req ? DATA : INST). Fixed priority data > inst when unlocked.
- mem_req = resetn & !fifo_full & granted master's req. The mem_* payload always muxes from the granted master.
- Address handshake (accept = mem_req & mem_addr_ok):
  - granted master's addr_ok = accept; the other master's addr_ok = 0.
  - On accept: push grant into FIFO; clear lock_valid.
  - mem_req=1 and !mem_addr_ok: set lock_valid=1 and lock_owner=grant. The grant cannot switch until accept, even if the other master raises req or the locked master drops req.
  - Locked master drops req before accept (protocol violation): lock persists, mem_req=0, and no push occurs.
- Response: on mem_data_ok with FIFO non-empty, pop the head. Owner-head's data_ok = 1; the other master's data_ok = 0.
- mem_data_ok with FIFO empty: no pop, no data_ok to either master, err_orphan_ok ← 1 until reset.
- Full: when count == OUTSTANDING, mem_req is forced 0 and both addr_ok are 0. A same-cycle pop does NOT unblock the push; the new request is accepted next cycle at earliest. This keeps the data_ok→req path out of the combinational logic.
- Simultaneous push and pop, not full: count unchanged, pointers both advance.
- Pointers wrap modulo OUTSTANDING.

## Timing
- Zero added latency: req→mem_req, mem_addr_ok→addr_ok, and mem_data_ok→data_ok are all combinational.
- State updates on posedge clk. Reset is asynchronous and takes effect immediately.
- Reset values:
  - lock_valid=0, lock_owner=0, FIFO empty, count=0, err_orphan_ok=0.
  - mem_req=0 (gated by resetn), all addr_ok/data_ok=0, outstanding_cnt=0.
  - mem_* payload follows the inst master; *_rdata = mem_rdata.
- Reset mid-transaction: outstanding entries are discarded. Later stale mem_data_ok raises err_orphan_ok. The bench resets the slave together with the arbiter.
- Back-to-back accepts are permitted every cycle while not full.

## Test plan
- Only inst_req, addr 0x1C000000, slave accepts same cycle, data_ok 2 cycles later with rdata 0x02800C0C -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 and inst_rdata=0x02800C0C in cycle 2; data_* handshakes stay 0; count goes 0→1→0.
- inst_req and data_req both high, unlocked -> data wins: mem_addr=data_addr, data_addr_ok on accept. Inst is granted the following cycle.
- inst granted, mem_addr_ok withheld 3 cycles while data_req rises in cycle 1 -> mem_addr stays inst_addr through cycle 3; inst accepted in cycle 3; data granted in cycle 4.
- OUTSTANDING=2, accept inst then data, with no responses -> third request sees mem_req=0 and count=2. First mem_data_ok goes to inst_data_ok only; the blocked request is accepted the next cycle; the second data_ok goes to data_data_ok.
- mem_data_ok pulse with FIFO empty -> no master data_ok and err_orphan_ok=1. Asserting resetn=0 mid-cycle clears it and count asynchronously.
